// File: rtl/gpio_disp_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : gpio_disp_pkg
//  Description : Shared constants, types and helpers for the GPIO
//                seven-segment scanner.
//  Contents    : NUM_DIGITS, digit_idx_t, SEG_BLANK, AN_OFF, top_digit()
//  Revision    : 1.0  initial release
// ============================================================================
package gpio_disp_pkg;

   localparam int         NUM_DIGITS = 8;
   localparam logic [6:0] SEG_BLANK  = 7'h7F;
   localparam logic [7:0] AN_OFF     = 8'hFF;

   typedef logic [2:0] digit_idx_t;

   // Index of the most-significant nonzero nibble; 0 when the value is zero,
   // so digit 0 always stays visible.
   function automatic digit_idx_t top_digit(input logic [31:0] value);
      digit_idx_t top;
      top = '0;
      for (int k = 0; k < NUM_DIGITS; k++) begin
         if (value[4*k +: 4] != 4'h0) top = digit_idx_t'(k);
      end
      return top;
   endfunction

endpackage
`default_nettype wire

// File: rtl/gpio_seg_scanner_if.sv
`default_nettype none
// ============================================================================
//  Module      : gpio_seg_scanner_if
//  Description : CPU-side gpio_out write bus of the seven-segment scanner.
//  Signals     : wr_en    - write strobe
//                wr_data  - eight hex nibbles, nibble k -> digit k
//                wr_dp    - decimal-point enables, bit k -> digit k
//                pending  - a written value awaits commit at frame wrap
//  Modports    : master (CPU), slave (scanner)
//  Revision    : 1.0  initial release
// ============================================================================
interface gpio_seg_scanner_if;

   logic        wr_en;
   logic [31:0] wr_data;
   logic [7:0]  wr_dp;
   logic        pending;

   modport master (output wr_en, output wr_data, output wr_dp, input  pending);
   modport slave  (input  wr_en, input  wr_data, input  wr_dp, output pending);

endinterface
`default_nettype wire

// File: rtl/hex_to_seg.sv
`default_nettype none
// ============================================================================
//  Module      : hex_to_seg
//  Description : Combinational hex nibble to seven-segment decoder.
//  Ports       : hex  in  4 - nibble to display
//                seg  out 7 - segments {g,f,e,d,c,b,a}, active-low
//  Revision    : 1.0  initial release
// ============================================================================
module hex_to_seg (
   input  logic [3:0] hex,
   output logic [6:0] seg
);

   always_comb begin
      seg = 7'b1111111;
      case (hex)
         4'h0: seg = 7'b1000000;
         4'h1: seg = 7'b1111001;
         4'h2: seg = 7'b0100100;
         4'h3: seg = 7'b0110000;
         4'h4: seg = 7'b0011001;
         4'h5: seg = 7'b0010010;
         4'h6: seg = 7'b0000010;
         4'h7: seg = 7'b1111000;
         4'h8: seg = 7'b0000000;
         4'h9: seg = 7'b0010000;
         4'hA: seg = 7'b0001000;
         4'hB: seg = 7'b0000011;
         4'hC: seg = 7'b1000110;
         4'hD: seg = 7'b0100001;
         4'hE: seg = 7'b0000110;
         4'hF: seg = 7'b0001110;
         default: seg = 7'b1111111;
      endcase
   end

endmodule
`default_nettype wire

// File: rtl/gpio_seg_scanner.sv
`default_nettype none
// ============================================================================
//  Module      : gpio_seg_scanner
//  Description : Eight-digit multiplexed seven-segment driver for a CPU
//                gpio_out register. Writes are staged in a pending register
//                and committed only at the frame wrap so a frame never tears.
//  Parameters  : SCAN_DIV - clk cycles each digit stays lit (1..2^20)
//  Macro       : GPIO_SEG_BLANK_EN - blank leading-zero digits (dp kept)
//  Ports       : clk      in  1 - clock, rising edge
//                rst      in  1 - asynchronous reset, active-low
//                bus      slave modport of gpio_seg_scanner_if
//                an_n     out 8 - digit enables, active-low
//                seg_n    out 7 - segments {g,f,e,d,c,b,a}, active-low
//                dp_n     out 1 - decimal point, active-low
//  Revision    : 1.0  initial release
// ============================================================================
module gpio_seg_scanner
   import gpio_disp_pkg::*;
#(
   parameter int unsigned SCAN_DIV = 50000
) (
   input  logic                       clk,
   input  logic                       rst,
   gpio_seg_scanner_if.slave          bus,
   output logic [NUM_DIGITS-1:0]      an_n,
   output logic [6:0]                 seg_n,
   output logic                       dp_n
);

   localparam int             CNT_W    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);

   logic [CNT_W-1:0]       prescale;
   digit_idx_t             idx;
   logic [31:0]            pend_data;
   logic [NUM_DIGITS-1:0]  pend_dp;
   logic                   pend_valid;
   logic [31:0]            disp_data;
   logic [NUM_DIGITS-1:0]  disp_dp;

   logic                   tick;
   logic                   wrap;
   logic [3:0]             nibble;
   logic [6:0]             seg_dec;
   logic                   blank;

   assign tick   = (prescale == CNT_LAST);
   assign wrap   = tick && (idx == digit_idx_t'(NUM_DIGITS - 1));
   assign nibble = disp_data[{idx, 2'b00} +: 4];

   hex_to_seg u_hex_to_seg (
      .hex (nibble),
      .seg (seg_dec)
   );

`ifdef GPIO_SEG_BLANK_EN
   assign blank = (idx > top_digit(disp_data));
`else
   assign blank = 1'b0;
`endif

   assign bus.pending = pend_valid;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         prescale   <= '0;
         idx        <= '0;
         pend_data  <= '0;
         pend_dp    <= '0;
         pend_valid <= 1'b0;
         disp_data  <= '0;
         disp_dp    <= '0;
         an_n       <= AN_OFF;
         seg_n      <= SEG_BLANK;
         dp_n       <= 1'b1;
      end else begin
         if (tick) begin
            prescale <= '0;
            idx      <= idx + 3'd1;
         end else begin
            prescale <= prescale + CNT_W'(1);
         end

         // A write landing on the wrap edge goes straight to the display;
         // otherwise it parks in the pending register (last write wins).
         if (wrap) begin
            pend_valid <= 1'b0;
            if (bus.wr_en) begin
               disp_data <= bus.wr_data;
               disp_dp   <= bus.wr_dp;
            end else if (pend_valid) begin
               disp_data <= pend_data;
               disp_dp   <= pend_dp;
            end
         end else if (bus.wr_en) begin
            pend_data  <= bus.wr_data;
            pend_dp    <= bus.wr_dp;
            pend_valid <= 1'b1;
         end

         // Outputs track the index/display as they stood before this edge.
         an_n  <= ~(8'b1 << idx);
         seg_n <= blank ? SEG_BLANK : seg_dec;
         dp_n  <= ~disp_dp[idx];
      end
   end

endmodule
`default_nettype wire
